// File: rtl/core_thermal_monitor.sv
// Per-core thermal monitor: polls a raw sensor over req/valid,
// box-car averages samples and publishes a hysteretic overtemp flag.
module core_thermal_monitor #(
  parameter int W             = 8,
  parameter int SAMPLE_PERIOD = 256,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 64,
  parameter int HI_THRESH     = 75,
  parameter int LO_THRESH     = 70
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_use,
  output logic         sens_req,
  input  logic         sens_valid,
  input  logic [W-1:0] sens_data,
  output logic [W-1:0] temperature,
  output logic         temp_valid,
  output logic         overtemp,
  output logic         sens_err
);

  localparam int TW  = $clog2(SAMPLE_PERIOD);
  localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW  = W + AVG_LOG2;

  localparam logic [TW-1:0]  TRELOAD = TW'(SAMPLE_PERIOD - 1);
  localparam logic [TOW-1:0] TOLAST  = TOW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CLAST   = CW'((1 << AVG_LOG2) - 1);
  localparam logic [W-1:0]   HI      = W'(HI_THRESH);
  localparam logic [W-1:0]   LO      = W'(LO_THRESH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_UPD  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [TW-1:0]  r_timer;
  logic [TOW-1:0] r_to_cnt;
  logic [AW-1:0]  r_acc;
  logic [CW-1:0]  r_smp_cnt;
  logic           r_in_use_q;
  logic [W-1:0]   r_sample;
  logic [W-1:0]   r_temp;
  logic           r_tvalid;
  logic           r_ovt;
  logic           r_err;

  logic           w_rise;
  logic           w_xfer;
  logic           w_tout;
  logic           w_last;
  logic [AW-1:0]  w_sum;
  logic [W-1:0]   w_avg;

  assign w_rise = in_use & ~r_in_use_q;
  assign w_xfer = (r_state == S_REQ) & sens_valid;
  assign w_tout = (r_state == S_REQ) & ~sens_valid
                & (r_to_cnt == TOLAST);
  assign w_sum  = r_acc + AW'(r_sample);
  assign w_avg  = W'(w_sum >> AVG_LOG2);
  assign w_last = (r_smp_cnt == CLAST);

  assign sens_req    = (r_state == S_REQ);
  assign temperature = r_temp;
  assign temp_valid  = r_tvalid;
  assign overtemp    = r_ovt;
  assign sens_err    = r_err;

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (r_timer == '0) w_next = S_REQ;
      S_REQ: begin
        if (w_xfer)      w_next = S_UPD;
        else if (w_tout) w_next = S_IDLE;
      end
      S_UPD:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // timers, accumulator and published results
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_timer    <= '0;
      r_to_cnt   <= '0;
      r_acc      <= '0;
      r_smp_cnt  <= '0;
      r_in_use_q <= 1'b0;
      r_sample   <= '0;
      r_temp     <= '0;
      r_tvalid   <= 1'b0;
      r_ovt      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_in_use_q <= in_use;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise)
            r_timer <= '0;
          else if (r_timer != '0)
            r_timer <= r_timer - 1'b1;
          if (r_timer == '0)
            r_to_cnt <= '0;
        end
        S_REQ: begin
          if (w_xfer) begin
            r_sample <= sens_data;
          end else if (w_tout) begin
            r_err   <= 1'b1;
            r_timer <= TRELOAD;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_UPD: begin
          r_err   <= 1'b0;
          r_timer <= TRELOAD;
          if (w_last) begin
            r_temp    <= w_avg;
            r_acc     <= '0;
            r_smp_cnt <= '0;
            r_tvalid  <= 1'b1;
            if (w_avg > HI)      r_ovt <= 1'b1;
            else if (w_avg < LO) r_ovt <= 1'b0;
          end else begin
            r_acc     <= w_sum;
            r_smp_cnt <= r_smp_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_thermal_monitor.sv
// Bench for core_thermal_monitor: scripted sensor responder with
// a queue of expected post-update results checked after each UPDATE.
module tb_core_thermal_monitor;

  typedef struct packed {
    logic [7:0] t;
    logic       o;
    logic       v;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_use = 1'b0;
  logic       sens_req;
  logic       sens_valid = 1'b0;
  logic [7:0] sens_data = '0;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       overtemp;
  logic       sens_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] data_q[$];
  exp_t       exp_q[$];
  int         resp_at = 1;
  logic       resp_en = 1'b1;
  int         sreq_cyc = 0;
  logic       xfer_pend = 1'b0;

  int         m_acc = 0;
  int         m_cnt = 0;
  logic [7:0] m_temp = '0;
  logic       m_ovt = 1'b0;
  logic       m_tv = 1'b0;

  core_thermal_monitor dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_use      (in_use),
    .sens_req    (sens_req),
    .sens_valid  (sens_valid),
    .sens_data   (sens_data),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .overtemp    (overtemp),
    .sens_err    (sens_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] d);
    m_acc += int'(d);
    m_cnt++;
    if (m_cnt == 4) begin
      m_temp = 8'(m_acc >> 2);
      if (m_temp > 8'd75)      m_ovt = 1'b1;
      else if (m_temp < 8'd70) m_ovt = 1'b0;
      m_tv  = 1'b1;
      m_acc = 0;
      m_cnt = 0;
    end
    exp_q.push_back('{t: m_temp, o: m_ovt, v: m_tv});
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_temp = '0;
    m_ovt  = 1'b0;
    m_tv   = 1'b0;
    exp_q.delete();
    data_q.delete();
    xfer_pend = 1'b0;
  endtask

  // sensor responder: answers on the resp_at-th REQ cycle
  always @(negedge CLK) begin
    if (RST || !sens_req) begin
      sreq_cyc   = 0;
      sens_valid = 1'b0;
    end else begin
      sreq_cyc++;
      if (resp_en && sreq_cyc == resp_at && data_q.size() > 0) begin
        sens_data  = data_q.pop_front();
        sens_valid = 1'b1;
        xfer_pend  = 1'b1;
        model_push(sens_data);
      end else begin
        sens_valid = 1'b0;
      end
    end
  end

  // result checker: compares state visible after the UPDATE edge
  always begin
    exp_t e;
    @(posedge CLK);
    if (xfer_pend) begin
      xfer_pend = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("temperature", 32'(temperature), 32'(e.t));
        chk("overtemp", 32'(overtemp), 32'(e.o));
        chk("temp_valid", 32'(temp_valid), 32'(e.v));
        chk("sens_err_upd", 32'(sens_err), 0);
      end
    end
  end

  task automatic wait_hi(output int lo);
    lo = 0;
    forever begin
      @(negedge CLK);
      if (sens_req) break;
      lo++;
      if (lo > 3000) begin
        chk("req_rise_tmo", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_lo(output int hi);
    hi = 1;
    forever begin
      @(negedge CLK);
      if (!sens_req) break;
      hi++;
      if (hi > 300) begin
        chk("req_fall_tmo", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_req(output int lo, output int hi);
    wait_hi(lo);
    wait_lo(hi);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int hi;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", 32'(sens_req), 0);
    chk("rst_temp", 32'(temperature), 0);
    chk("rst_tv", 32'(temp_valid), 0);
    chk("rst_ovt", 32'(overtemp), 0);
    chk("rst_err", 32'(sens_err), 0);

    repeat (4) data_q.push_back(8'd80);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rel_req0", 32'(sens_req), 0);
    @(posedge CLK);
    #1;
    chk("rel_req1", 32'(sens_req), 1);
    for (int i = 0; i < 4; i++) begin
      wait_req(lo, hi);
      chk("req_width", hi, 1);
      if (i > 0) chk("idle_gap", lo, 256);
    end
    repeat (3) @(negedge CLK);

    data_q.push_back(8'd10);
    repeat (3) data_q.push_back(8'd11);
    for (int i = 0; i < 4; i++) wait_req(lo, hi);

    repeat (4) data_q.push_back(8'd80);
    repeat (4) data_q.push_back(8'd72);
    repeat (4) data_q.push_back(8'd69);
    repeat (4) data_q.push_back(8'd72);
    for (int i = 0; i < 16; i++) wait_req(lo, hi);
    repeat (3) @(negedge CLK);

    data_q.push_back(8'd20);
    wait_req(lo, hi);
    repeat (3) @(negedge CLK);
    resp_en = 1'b0;
    wait_req(lo, hi);
    chk("tmo_width", hi, 64);
    chk("tmo_err", 32'(sens_err), 1);
    chk("tmo_temp", 32'(temperature), 32'(m_temp));
    resp_en = 1'b1;
    data_q.push_back(8'd50);
    wait_req(lo, hi);
    chk("tmo_gap", lo, 255);
    repeat (3) @(negedge CLK);
    resp_at = 64;
    data_q.push_back(8'd30);
    wait_req(lo, hi);
    chk("late_width", hi, 64);
    repeat (3) @(negedge CLK);
    resp_at = 1;
    data_q.push_back(8'd40);
    wait_req(lo, hi);
    repeat (3) @(negedge CLK);

    repeat (60) @(negedge CLK);
    data_q.push_back(8'd80);
    in_use = 1'b1;
    @(posedge CLK);
    #1;
    chk("fast_req0", 32'(sens_req), 0);
    @(posedge CLK);
    #1;
    chk("fast_req1", 32'(sens_req), 1);
    wait_req(lo, hi);
    in_use  = 1'b0;
    resp_at = 5;
    data_q.push_back(8'd80);
    wait_hi(lo);
    in_use = 1'b1;
    wait_lo(hi);
    chk("inuse_req_width", hi, 5);
    resp_at = 1;
    data_q.push_back(8'd80);
    wait_req(lo, hi);
    chk("inuse_req_gap", lo, 256);
    in_use = 1'b0;
    data_q.push_back(8'd80);
    wait_req(lo, hi);
    repeat (3) @(negedge CLK);

    data_q.push_back(8'd90);
    data_q.push_back(8'd90);
    wait_req(lo, hi);
    wait_req(lo, hi);
    repeat (3) @(negedge CLK);
    resp_at = 10;
    wait_hi(lo);
    #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_req", 32'(sens_req), 0);
    chk("mid_rst_temp", 32'(temperature), 0);
    chk("mid_rst_tv", 32'(temp_valid), 0);
    chk("mid_rst_ovt", 32'(overtemp), 0);
    model_reset();
    resp_at = 1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) data_q.push_back(8'd60);
    for (int i = 0; i < 4; i++) wait_req(lo, hi);
    repeat (4) @(negedge CLK);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
